// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for 1280x1024@60 (108 MHz pixel clock).
// Free-running horizontal/vertical counters drive the coordinate outputs directly.
// Sync and active are decoded from the counters, then delayed PIPE_DLY clocks so
// they line up with the registered colour stage. frameStart and lineEnd are not
// delayed, because the sample-buffer logic uses them against the live coordinates.
//
// Phase decode. It is applied to hcnt in clocks and to vcnt in lines, and it needs
// no extra state registers:
//   state   | meaning
//   PH_ACT  | visible region, cnt < VISIBLE
//   PH_FP   | front porch
//   PH_SYNC | sync pulse asserted (level SYNC_POL)
//   PH_BP   | back porch; the counter wrap returns to PH_ACT
module vga_timing_gen #(
  parameter int H_VISIBLE = 1280,
  parameter int H_FP      = 48,
  parameter int H_SYNC    = 112,
  parameter int H_BP      = 248,
  parameter int V_VISIBLE = 1024,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 3,
  parameter int V_BP      = 38,
  parameter bit SYNC_POL  = 1'b1,
  parameter int PIPE_DLY  = 1
) (
  input  logic        CLK_VGA,
  input  logic        RESET,
  output logic [11:0] VGA_horzCoord,
  output logic [11:0] VGA_vertCoord,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_active,
  output logic        VGA_frameStart,
  output logic        VGA_lineEnd
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // The phase boundaries are held at the full 12-bit counter width, so every
  // compare works on matching widths.
  localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_FP_START   = 12'(H_VISIBLE);
  localparam logic [11:0] H_SYNC_START = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] H_BP_START   = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [11:0] V_FP_START   = 12'(V_VISIBLE);
  localparam logic [11:0] V_SYNC_START = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] V_BP_START   = 12'(V_VISIBLE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_t;

  logic [11:0] hcnt;
  logic [11:0] vcnt;
  phase_t      h_phase;
  phase_t      v_phase;
  logic        hs_raw;
  logic        vs_raw;
  logic        act_raw;

  function automatic phase_t decode_phase(
    input logic [11:0] cnt,
    input logic [11:0] fp_start,
    input logic [11:0] sync_start,
    input logic [11:0] bp_start
  );
    phase_t ph;
    if (cnt < fp_start)
      ph = PH_ACT;
    else if (cnt < sync_start)
      ph = PH_FP;
    else if (cnt < bp_start)
      ph = PH_SYNC;
    else
      ph = PH_BP;
    return ph;
  endfunction

  // Raster counters. The line counter advances only on a horizontal wrap. Reset
  // drops any frame in progress and restarts the raster at (0,0).
  always_ff @(posedge CLK_VGA) begin
    if (RESET) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      hcnt <= '0;
      if (vcnt == V_LAST)
        vcnt <= '0;
      else
        vcnt <= vcnt + 12'd1;
    end else begin
      hcnt <= hcnt + 12'd1;
    end
  end

  // Decode the horizontal and vertical phases from the live counters.
  always_comb begin
    h_phase = decode_phase(hcnt, H_FP_START, H_SYNC_START, H_BP_START);
    v_phase = decode_phase(vcnt, V_FP_START, V_SYNC_START, V_BP_START);
  end

  // Undelayed sync and active levels. vs_raw depends only on vcnt, so it spans whole lines.
  always_comb begin
    hs_raw  = (h_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    vs_raw  = (v_phase == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
    act_raw = (h_phase == PH_ACT) && (v_phase == PH_ACT);
  end

  assign VGA_horzCoord  = hcnt;
  assign VGA_vertCoord  = vcnt;
  assign VGA_lineEnd    = (hcnt == H_LAST);
  assign VGA_frameStart = ~RESET && (hcnt == 12'd0) && (vcnt == 12'd0);

  generate
    if (PIPE_DLY == 0) begin : g_no_pipe
      // With no delay, the outputs follow the raw decode of the current counters.
      always_comb begin
        VGA_HS     = hs_raw;
        VGA_VS     = vs_raw;
        VGA_active = act_raw;
      end
    end else begin : g_pipe
      logic [PIPE_DLY-1:0] hs_pipe;
      logic [PIPE_DLY-1:0] vs_pipe;
      logic [PIPE_DLY-1:0] act_pipe;

      // Delay line for sync and active. Every stage resets to the inactive level.
      always_ff @(posedge CLK_VGA) begin
        if (RESET) begin
          hs_pipe  <= {PIPE_DLY{~SYNC_POL}};
          vs_pipe  <= {PIPE_DLY{~SYNC_POL}};
          act_pipe <= '0;
        end else begin
          hs_pipe[0]  <= hs_raw;
          vs_pipe[0]  <= vs_raw;
          act_pipe[0] <= act_raw;
          for (int i = 1; i < PIPE_DLY; i++) begin
            hs_pipe[i]  <= hs_pipe[i-1];
            vs_pipe[i]  <= vs_pipe[i-1];
            act_pipe[i] <= act_pipe[i-1];
          end
        end
      end

      // The last stage of each delay line drives the port.
      always_comb begin
        VGA_HS     = hs_pipe[PIPE_DLY-1];
        VGA_VS     = vs_pipe[PIPE_DLY-1];
        VGA_active = act_pipe[PIPE_DLY-1];
      end
    end
  endgenerate

endmodule
